// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   - FSM state encoding (state_e), opcode/funct constants
//   - ALUSrcB / PCSrc / ALUControl encodings, ALUOp codes
//   - decode_next_state(): DECODE-state dispatch on opcode
// Optional feature macro: MC_CTRL_EXT_EN (adds BNE, ANDI, ORI).
package mips_mc_pkg;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StImmEx  = 4'd9,
      StImmWb  = 4'd10,
      StJump   = 4'd11,
      StMerr   = 4'd12,
      StIll    = 4'd13
   } state_e;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpJ     = 6'b000010;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnSlt = 6'b101010;

   // ALUSrcB select
   localparam logic [2:0] SrcBReg     = 3'd0;
   localparam logic [2:0] SrcBFour    = 3'd1;
   localparam logic [2:0] SrcBImm     = 3'd2;
   localparam logic [2:0] SrcBImmSh   = 3'd3;
   localparam logic [2:0] SrcBZeroImm = 3'd4;

   // PCSrc select
   localparam logic [1:0] PcSrcAlu    = 2'd0;
   localparam logic [1:0] PcSrcAluOut = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;

   // ALUControl encodings
   localparam logic [2:0] AluAdd = 3'b010;
   localparam logic [2:0] AluSub = 3'b110;
   localparam logic [2:0] AluAnd = 3'b000;
   localparam logic [2:0] AluOr  = 3'b001;
   localparam logic [2:0] AluSlt = 3'b111;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10,
      AluOpLogic = 2'b11
   } alu_op_e;

   // Where DECODE goes for a given opcode; anything undecodable traps.
   function automatic state_e decode_next_state(input logic [5:0] op);
      state_e nxt;
      case (op)
         OpRtype:    nxt = StExec;
         OpLw, OpSw: nxt = StMemAdr;
         OpBeq:      nxt = StBranch;
         OpAddi:     nxt = StImmEx;
         OpJ:        nxt = StJump;
`ifdef MC_CTRL_EXT_EN
         OpBne:         nxt = StBranch;
         OpAndi, OpOri: nxt = StImmEx;
`endif
         default:    nxt = StIll;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder.
//   alu_op      in  2  ALUOp code (add / sub / funct / logic-imm)
//   funct       in  6  instr[5:0]
//   op          in  6  instr[31:26], selects and/or for logic-imm ops
//   alu_control out 3  ALU operation
//   funct_valid out 1  0 when ALUOp=funct and funct is not supported
// Optional feature macro: MC_CTRL_EXT_EN (logic-imm decode of ANDI/ORI).
module mips_alu_decoder
   import mips_mc_pkg::*;
(
   input  alu_op_e     alu_op,
   input  logic [5:0]  funct,
   input  logic [5:0]  op,
   output logic [2:0]  alu_control,
   output logic        funct_valid
);

`ifndef MC_CTRL_EXT_EN
   // op only matters for the extended logic-immediate ops
   logic unused_op;
   assign unused_op = ^op;
`endif

   always_comb begin
      alu_control = AluAdd;
      funct_valid = 1'b1;
      case (alu_op)
         AluOpAdd: alu_control = AluAdd;
         AluOpSub: alu_control = AluSub;
         AluOpFunct: begin
            case (funct)
               FnAdd:   alu_control = AluAdd;
               FnSub:   alu_control = AluSub;
               FnAnd:   alu_control = AluAnd;
               FnOr:    alu_control = AluOr;
               FnSlt:   alu_control = AluSlt;
               default: begin
                  alu_control = 3'b000;
                  funct_valid = 1'b0;
               end
            endcase
         end
         AluOpLogic: begin
`ifdef MC_CTRL_EXT_EN
            alu_control = (op == OpOri) ? AluOr : AluAnd;
`else
            alu_control = AluAdd;
`endif
         end
         default: alu_control = AluAdd;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM with a req/ready memory handshake,
// programmable memory timeout and illegal-instruction trapping.
// Ports:
//   clk, reset (sync, active-low)     reset forces every output to 0
//   op, funct, zero                   instruction fields and ALU zero flag
//   mem_ready                         memory completes request this cycle
//   state                             current FSM state
//   mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn   datapath controls
//   illegal                           one-cycle trap pulse (ILL state)
//   mem_err                           sticky memory-timeout flag
// Parameters: MEM_TIMEOUT (0 disables), TO_W derived counter width.
// Optional feature macro: MC_CTRL_EXT_EN (BNE, ANDI, ORI).
module mips_mc_controller
   import mips_mc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] state,
   output logic       mem_req,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [2:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       illegal,
   output logic       mem_err
);

   localparam int unsigned CntW = (TO_W > 0) ? TO_W : 1;
   localparam bit ToEn = (MEM_TIMEOUT != 0);
   localparam logic [CntW-1:0] ToLast = ToEn ? CntW'(MEM_TIMEOUT - 1) : '0;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            mem_err_q, mem_err_d;

   alu_op_e    alu_op;
   logic [2:0] dec_ctrl;
   logic       funct_valid;
   logic       alu_use;

   mips_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct       (funct),
      .op          (op),
      .alu_control (dec_ctrl),
      .funct_valid (funct_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Next state and wait counter. In the three request states, a completing
   // mem_ready takes priority over an expiring timeout.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q;
      case (state_q)
         StFetch, StMemRd, StMemWr: begin
            if (mem_ready) begin
               cnt_d = '0;
               case (state_q)
                  StFetch: state_d = StDecode;
                  StMemRd: state_d = StMemWb;
                  default: state_d = StFetch;
               endcase
            end else if (ToEn && (cnt_q == ToLast)) begin
               state_d   = StMerr;
               mem_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDecode: state_d = decode_next_state(op);
         StMemAdr: state_d = (op == OpSw) ? StMemWr : StMemRd;
         StMemWb:  state_d = StFetch;
         StExec:   state_d = funct_valid ? StAluWb : StIll;
         StAluWb:  state_d = StFetch;
         StBranch: state_d = StFetch;
         StImmEx:  state_d = StImmWb;
         StImmWb:  state_d = StFetch;
         StJump:   state_d = StFetch;
         StMerr:   state_d = StMerr;
         StIll:    state_d = StFetch;
         default:  state_d = StFetch;
      endcase
      // Each fresh wait starts from zero.
      if ((state_d != state_q) &&
          ((state_d == StFetch) || (state_d == StMemRd) || (state_d == StMemWr))) begin
         cnt_d = '0;
      end
   end

   // Control outputs; FETCH and BRANCH also look at mem_ready / zero.
   always_comb begin
      mem_req  = 1'b0;
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SrcBReg;
      PCSrc    = PcSrcAlu;
      PCEn     = 1'b0;
      illegal  = 1'b0;
      alu_op   = AluOpAdd;
      alu_use  = 1'b0;
      case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            ALUSrcB = SrcBFour;
            alu_use = 1'b1;
            IRWrite = mem_ready;
            PCEn    = mem_ready;
         end
         StDecode: begin
            ALUSrcB = SrcBImmSh;
            alu_use = 1'b1;
         end
         StMemAdr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SrcBImm;
            alu_use = 1'b1;
         end
         StMemRd: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
         end
         StMemWb: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         StMemWr: begin
            mem_req  = 1'b1;
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         StExec: begin
            ALUSrcA = 1'b1;
            alu_op  = AluOpFunct;
            alu_use = 1'b1;
         end
         StAluWb: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         StBranch: begin
            ALUSrcA = 1'b1;
            alu_op  = AluOpSub;
            alu_use = 1'b1;
            PCSrc   = PcSrcAluOut;
`ifdef MC_CTRL_EXT_EN
            PCEn    = (op == OpBne) ? !zero : zero;
`else
            PCEn    = zero;
`endif
         end
         StImmEx: begin
            ALUSrcA = 1'b1;
            alu_use = 1'b1;
            ALUSrcB = SrcBImm;
`ifdef MC_CTRL_EXT_EN
            if (op != OpAddi) begin
               ALUSrcB = SrcBZeroImm;
               alu_op  = AluOpLogic;
            end
`endif
         end
         StImmWb: RegWrite = 1'b1;
         StJump: begin
            PCSrc = PcSrcJump;
            PCEn  = 1'b1;
         end
         StIll:   illegal = 1'b1;
         default: ;
      endcase
      ALUControl = alu_use ? dec_ctrl : 3'b000;
      if (!reset) begin
         mem_req    = 1'b0;
         IorD       = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegDst     = 1'b0;
         MemtoReg   = 1'b0;
         RegWrite   = 1'b0;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 3'b000;
         ALUControl = 3'b000;
         PCSrc      = 2'b00;
         PCEn       = 1'b0;
         illegal    = 1'b0;
      end
   end

   assign state   = reset ? state_q : StFetch;
   assign mem_err = reset & mem_err_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed self-checking bench for mips_mc_controller (MEM_TIMEOUT=4).
// Expected ORI behaviour follows MC_CTRL_EXT_EN.
module tb_mips_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic [3:0] state;
   logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [2:0] ALUSrcB, ALUControl;
   logic [1:0] PCSrc;
   logic       PCEn, illegal, mem_err;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   mips_mc_controller #(.MEM_TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .state      (state),
      .mem_req    (mem_req),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .PCSrc      (PCSrc),
      .PCEn       (PCEn),
      .illegal    (illegal),
      .mem_err    (mem_err)
   );

   always #5 clk = ~clk;

   // {mem_req,IorD,MemWrite,IRWrite, RegDst,MemtoReg,RegWrite,ALUSrcA,
   //  ALUSrcB, ALUControl, PCSrc, PCEn,illegal,mem_err}
   logic [18:0] ctrl;
   assign ctrl = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, PCEn, illegal, mem_err};

   localparam logic [18:0] CZero    = '0;
   localparam logic [18:0] CFetchW  = {4'b1000, 4'b0000, 3'd1, 3'b010, 2'd0, 3'b000};
   localparam logic [18:0] CFetchR  = {4'b1001, 4'b0000, 3'd1, 3'b010, 2'd0, 3'b100};
   localparam logic [18:0] CDecode  = {4'b0000, 4'b0000, 3'd3, 3'b010, 2'd0, 3'b000};
   localparam logic [18:0] CMemAdr  = {4'b0000, 4'b0001, 3'd2, 3'b010, 2'd0, 3'b000};
   localparam logic [18:0] CMemRd   = {4'b1100, 4'b0000, 3'd0, 3'b000, 2'd0, 3'b000};
   localparam logic [18:0] CMemWb   = {4'b0000, 4'b0110, 3'd0, 3'b000, 2'd0, 3'b000};
   localparam logic [18:0] CExecSlt = {4'b0000, 4'b0001, 3'd0, 3'b111, 2'd0, 3'b000};
   localparam logic [18:0] CAluWb   = {4'b0000, 4'b1010, 3'd0, 3'b000, 2'd0, 3'b000};
   localparam logic [18:0] CBrTaken = {4'b0000, 4'b0001, 3'd0, 3'b110, 2'd1, 3'b100};
   localparam logic [18:0] CBrNot   = {4'b0000, 4'b0001, 3'd0, 3'b110, 2'd1, 3'b000};
   localparam logic [18:0] COriEx   = {4'b0000, 4'b0001, 3'd4, 3'b001, 2'd0, 3'b000};
   localparam logic [18:0] CImmWb   = {4'b0000, 4'b0010, 3'd0, 3'b000, 2'd0, 3'b000};
   localparam logic [18:0] CJump    = {4'b0000, 4'b0000, 3'd0, 3'b000, 2'd2, 3'b100};
   localparam logic [18:0] CIll     = {4'b0000, 4'b0000, 3'd0, 3'b000, 2'd0, 3'b010};
   localparam logic [18:0] CMerr    = {4'b0000, 4'b0000, 3'd0, 3'b000, 2'd0, 3'b001};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Let inputs settle, then compare state and the full control vector.
   task automatic expect_st(input string tag, input logic [3:0] st, input logic [18:0] c);
      #1;
      check({tag, "/state"}, 32'(state), 32'(st));
      check({tag, "/ctrl"}, 32'(ctrl), 32'(c));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; mem_ready = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;

      // Reset held two cycles
      expect_st("rst_a", 4'd0, CZero);
      tick();
      expect_st("rst_b", 4'd0, CZero);
      tick();
      reset = 1'b1;
      expect_st("fetch_first", 4'd0, CFetchR);
      tick();
      expect_st("decode_lw", 4'd1, CDecode);

      // LW with three stalled MEMRD cycles
      tick();
      mem_ready = 1'b0;
      expect_st("memadr", 4'd2, CMemAdr);
      tick();
      expect_st("memrd_w1", 4'd3, CMemRd);
      tick();
      expect_st("memrd_w2", 4'd3, CMemRd);
      tick();
      expect_st("memrd_w3", 4'd3, CMemRd);
      tick();
      mem_ready = 1'b1;
      expect_st("memrd_rdy", 4'd3, CMemRd);
      tick();
      expect_st("memwb", 4'd4, CMemWb);
      tick();

      // SLT
      op = 6'b000000; funct = 6'b101010;
      expect_st("fetch_slt", 4'd0, CFetchR);
      tick();
      expect_st("decode_slt", 4'd1, CDecode);
      tick();
      expect_st("exec_slt", 4'd6, CExecSlt);
      tick();
      expect_st("aluwb", 4'd7, CAluWb);
      tick();

      // Undefined funct traps
      funct = 6'b111111;
      expect_st("fetch_badfn", 4'd0, CFetchR);
      tick();
      tick();
      #1 check("exec_badfn/state", 32'(state), 32'd6);
      tick();
      expect_st("ill_fn", 4'd13, CIll);
      tick();
      expect_st("after_ill", 4'd0, CFetchR);
      tick();

      // BEQ taken and not taken
      op = 6'b000100; zero = 1'b1;
      tick();
      expect_st("beq_taken", 4'd8, CBrTaken);
      tick();
      expect_st("fetch_beq", 4'd0, CFetchR);
      zero = 1'b0;
      tick();
      tick();
      expect_st("beq_not", 4'd8, CBrNot);
      tick();

      // ORI (extended op)
      op = 6'b001101;
      tick();
      tick();
`ifdef MC_CTRL_EXT_EN
      expect_st("ori_ex", 4'd9, COriEx);
      tick();
      expect_st("ori_wb", 4'd10, CImmWb);
`else
      expect_st("ori_ill", 4'd13, CIll);
`endif
      tick();

      // J
      op = 6'b000010;
      tick();
      tick();
      expect_st("jump", 4'd11, CJump);
      tick();

      // Memory timeout in FETCH after four request cycles
      mem_ready = 1'b0;
      expect_st("to_w0", 4'd0, CFetchW);
      tick();
      expect_st("to_w1", 4'd0, CFetchW);
      tick();
      expect_st("to_w2", 4'd0, CFetchW);
      tick();
      expect_st("to_w3", 4'd0, CFetchW);
      tick();
      expect_st("merr", 4'd12, CMerr);
      mem_ready = 1'b1;
      tick();
      expect_st("merr_held", 4'd12, CMerr);

      // Reset clears the sticky error
      reset = 1'b0;
      expect_st("rst_merr", 4'd0, CZero);
      tick();
      reset = 1'b1; mem_ready = 1'b0;
      expect_st("post_rst", 4'd0, CFetchW);

      // mem_ready on the last allowed cycle beats the timeout
      tick();
      tick();
      tick();
      mem_ready = 1'b1;
      expect_st("to_edge_rdy", 4'd0, CFetchR);
      tick();
      expect_st("to_edge_dec", 4'd1, CDecode);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Parametrised multicycle MIPS control unit: Moore FSM plus ALU decoder driving the datapath controls (IorD, ALUSrcA/B, PCSrc, MemWrite, RegWrite, …).
- Successor to the fixed-memory controller. Adds a req/ready memory handshake with a programmable timeout, illegal-opcode trapping, and optional extended ops.
- Sits between the instruction register (op/funct), the ALU zero flag and the memory port, inside the top-level MIPS module.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready before error; 0 disables the timeout.
- TO_W, $clog2(MEM_TIMEOUT+1), wait-counter width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- state  out  4  current FSM state encoding.
- mem_req  out  1  memory access request.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  1 = rd, 0 = rt.
- MemtoReg  out  1  1 = Data, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  3  0 = B, 1 = 4, 2 = SignImm, 3 = SignImm<<2, 4 = ZeroImm.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  out  2  0 = ALUResult, 1 = ALUOut, 2 = jump target.
- PCEn  out  1  PC load enable.
- illegal  out  1  one-cycle pulse on an undecodable opcode/funct.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (reset==0 at a clk edge): state <= FETCH, wait counter <= 0, mem_err <= 0. While reset is low, every control output is forced to 0 regardless of state. Reset mid-operation aborts immediately; no partial write continues.
- States:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, MERR=12, ILL=13.
- FETCH:
  - Outputs: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=1, add, PCSrc=0.
  - Stay while mem_ready=0. On mem_ready=1, the same cycle asserts IRWrite=1 and PCEn=1, then -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, add (branch target into ALUOut). Next state by op:
  - R -> EXEC
  - LW/SW -> MEMADR
  - BEQ(/BNE) -> BRANCH
  - ADDI(/ANDI/ORI) -> IMMEX
  - J -> JUMP
  - anything else -> ILL
- MEMADR: ALUSrcA=1, ALUSrcB=2, add. LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_req=1, IorD=1. Stay until mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. -> FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1, held every waiting cycle. On mem_ready -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUControl from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct -> ILL instead of ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, sub, PCSrc=1. PCEn=zero (BEQ), PCEn=!zero (BNE). -> FETCH.
- IMMEX: ALUSrcA=1. ADDI uses ALUSrcB=2 with add; ANDI/ORI use ALUSrcB=4 with and/or. -> IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
- JUMP: PCSrc=2, PCEn=1. -> FETCH.
- ILL: illegal=1 for exactly one cycle, no register or memory write. The already-incremented PC is kept (instruction skipped). -> FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEMRD/MEMWR and on every mem_ready.
  - Increments each mem_req cycle without mem_ready.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with mem_ready still 0: next state MERR, mem_err <= 1.
  - mem_ready in that same cycle wins over the timeout.
- MERR: all controls 0, mem_err=1. Held until reset.
- Unlisted encodings 14/15 -> FETCH next cycle, all controls 0.
- Unused outputs in each state are 0.

Optional Feature:
- Macro MC_CTRL_EXT_EN.
- Defined: BNE (000101), ANDI (001100) and ORI (001101) are decoded as above.
- Undefined: those opcodes -> ILL with an illegal pulse; ALUSrcB value 4 is never driven.

Decomposition:
- Package mips_mc_pkg holds:
  - state localparams,
  - opcode and funct constants,
  - ALUSrcB/PCSrc/ALUControl encodings,
  - ALUOp codes (00 add, 01 sub, 10 funct, 11 logic-imm).
- Sub-module mips_alu_decoder is combinational: ALUOp + funct + op -> ALUControl + funct_valid.

Test Plan:
- Reset held low 2 cycles, then released with mem_ready=1 → all outputs 0 during reset; state=0 then 1; IRWrite and PCEn pulse 1 cycle.
- op=100011 (LW), mem_ready delayed 3 cycles in MEMRD → state sequence 0,1,2,3,3,3,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- op=000000, funct=101010 (SLT) → ALUControl=111 in EXEC; RegDst=1, RegWrite=1 in ALUWB; funct=111111 → illegal pulse, no RegWrite.
- op=000100 (BEQ) with zero=1 → PCEn=1, PCSrc=1 in state 8; with zero=0 → PCEn=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → state 12 after 4 request cycles, mem_err=1 held; reset low clears it to state 0.
- op=001101 (ORI) → with MC_CTRL_EXT_EN: ALUSrcB=4, ALUControl=001, RegWrite in state 10; without the macro: state 13, illegal=1.
